reorder_buffer: RTL and testbench

Circular reorder buffer for the Tomasulo core. It allocates a tag per dispatched instruction and collects results from the ALU and LSB result buses. It retires instructions in program order, producing the commit stream (signal, tag, data, target register) that the register file consumes. It also answers operand-forwarding queries from the decoder and raises a pipeline flush on branch misprediction.

---
 rtl/reorder_buffer_pkg.sv | 39 +++
 rtl/rob_query_port.sv | 39 +++
 rtl/reorder_buffer.sv | 221 ++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, entry layout and tag/index helpers for the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE   = 16;
  localparam int unsigned TAG_WIDTH  = 5;
  localparam int unsigned IDX_WIDTH  = $clog2(ROB_SIZE);
  localparam int unsigned CNT_WIDTH  = IDX_WIDTH + 1;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned REG_WIDTH  = 5;

  localparam logic [TAG_WIDTH-1:0]  NULL_TAG  = '0;
  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    logic [REG_WIDTH-1:0]  rd;
    logic                  has_rd;
    logic                  is_branch;
    logic                  is_store;
    logic                  pred_taken;
    logic                  taken;
    logic [WORD_WIDTH-1:0] value;
  } rob_entry_t;

  // A tag names a real entry only when it is non-NULL and within the buffer.
  function automatic logic tag_valid(input logic [TAG_WIDTH-1:0] tag);
    return (tag != NULL_TAG) && (32'(tag) <= ROB_SIZE);
  endfunction

  function automatic logic [IDX_WIDTH-1:0] tag_to_idx(input logic [TAG_WIDTH-1:0] tag);
    return IDX_WIDTH'(tag - TAG_WIDTH'(1));
  endfunction

  function automatic logic [TAG_WIDTH-1:0] idx_to_tag(input logic [IDX_WIDTH-1:0] idx);
    return TAG_WIDTH'(idx) + TAG_WIDTH'(1);
  endfunction

endpackage

// File: rtl/rob_query_port.sv
// Operand lookup: result-bus bypass (ALU first) ahead of the stored entry value.
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  logic [TAG_WIDTH-1:0]  tag_in,
  input  logic [ROB_SIZE-1:0]   ready_vec_in,
  input  logic [WORD_WIDTH-1:0] value_vec_in [ROB_SIZE],
  input  logic                  alu_valid_in,
  input  logic [TAG_WIDTH-1:0]  alu_tag_in,
  input  logic [WORD_WIDTH-1:0] alu_data_in,
  input  logic                  lsb_valid_in,
  input  logic [TAG_WIDTH-1:0]  lsb_tag_in,
  input  logic [WORD_WIDTH-1:0] lsb_data_in,
  output logic                  ready_c,
  output logic [WORD_WIDTH-1:0] value_c
);

  logic [IDX_WIDTH-1:0] idx_c;

  assign idx_c = tag_to_idx(tag_in);

  always_comb begin
    ready_c = 1'b0;
    value_c = ZERO_WORD;
    if (tag_valid(tag_in)) begin
      if (alu_valid_in && (alu_tag_in == tag_in)) begin
        ready_c = 1'b1;
        value_c = alu_data_in;
      end else if (lsb_valid_in && (lsb_tag_in == tag_in)) begin
        ready_c = 1'b1;
        value_c = lsb_data_in;
      end else if (ready_vec_in[idx_c]) begin
        ready_c = 1'b1;
        value_c = value_vec_in[idx_c];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order write-back, in-order
// commit with store release and branch-mispredict flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  output logic [TAG_WIDTH-1:0]  dis_tag_out,
  output logic                  rob_full_out,
  input  logic                  dec_issue_in,
  input  logic [REG_WIDTH-1:0]  dec_rd_in,
  input  logic                  dec_has_rd_in,
  input  logic                  dec_is_branch_in,
  input  logic                  dec_is_store_in,
  input  logic                  dec_pred_taken_in,
  input  logic [TAG_WIDTH-1:0]  dec_q1_tag_in,
  input  logic [TAG_WIDTH-1:0]  dec_q2_tag_in,
  output logic                  dec_q1_ready_out,
  output logic                  dec_q2_ready_out,
  output logic [WORD_WIDTH-1:0] dec_q1_value_out,
  output logic [WORD_WIDTH-1:0] dec_q2_value_out,
  input  logic                  alu_valid_in,
  input  logic [TAG_WIDTH-1:0]  alu_tag_in,
  input  logic [WORD_WIDTH-1:0] alu_data_in,
  input  logic                  alu_taken_in,
  input  logic                  lsb_valid_in,
  input  logic [TAG_WIDTH-1:0]  lsb_tag_in,
  input  logic [WORD_WIDTH-1:0] lsb_data_in,
  output logic                  rob_commit_signal_out,
  output logic [TAG_WIDTH-1:0]  rob_commit_tag_out,
  output logic [WORD_WIDTH-1:0] rob_commit_data_out,
  output logic [REG_WIDTH-1:0]  rob_commit_target_out,
  output logic                  rob_store_commit_out,
  output logic [TAG_WIDTH-1:0]  rob_store_tag_out,
  output logic                  rob_flush_out,
  output logic [WORD_WIDTH-1:0] rob_flush_pc_out
);

  rob_entry_t            entries_q [ROB_SIZE];
  rob_entry_t            entries_d [ROB_SIZE];
  logic [IDX_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic                  commit_signal_q, commit_signal_d;
  logic [TAG_WIDTH-1:0]  commit_tag_q, commit_tag_d;
  logic [WORD_WIDTH-1:0] commit_data_q, commit_data_d;
  logic [REG_WIDTH-1:0]  commit_target_q, commit_target_d;
  logic                  store_commit_q, store_commit_d;
  logic [TAG_WIDTH-1:0]  store_tag_q, store_tag_d;
  logic                  flush_q, flush_d;
  logic [WORD_WIDTH-1:0] flush_pc_q, flush_pc_d;

  logic                  full_c, alloc_c, commit_c, mispredict_c;
  logic                  alu_hit_c, lsb_hit_c;
  logic [IDX_WIDTH-1:0]  alu_idx_c, lsb_idx_c;
  rob_entry_t            head_entry_c;
  logic [ROB_SIZE-1:0]   ready_vec_c;
  logic [WORD_WIDTH-1:0] value_vec_c [ROB_SIZE];

  assign full_c       = (count_q == CNT_WIDTH'(ROB_SIZE));
  assign alloc_c      = dec_issue_in && !full_c;
  assign head_entry_c = entries_q[head_q];
  assign commit_c     = head_entry_c.busy && head_entry_c.ready;
  assign mispredict_c = commit_c && head_entry_c.is_branch &&
                        (head_entry_c.taken != head_entry_c.pred_taken);

  assign alu_idx_c = tag_to_idx(alu_tag_in);
  assign lsb_idx_c = tag_to_idx(lsb_tag_in);
  assign alu_hit_c = alu_valid_in && tag_valid(alu_tag_in) && entries_q[alu_idx_c].busy;
  assign lsb_hit_c = lsb_valid_in && tag_valid(lsb_tag_in) && entries_q[lsb_idx_c].busy;

  assign rob_full_out = full_c;
  assign dis_tag_out  = idx_to_tag(tail_q);

  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      ready_vec_c[i] = entries_q[i].ready;
      value_vec_c[i] = entries_q[i].value;
    end
  end

  rob_query_port u_query_q1 (
    .tag_in       (dec_q1_tag_in),
    .ready_vec_in (ready_vec_c),
    .value_vec_in (value_vec_c),
    .alu_valid_in (alu_valid_in),
    .alu_tag_in   (alu_tag_in),
    .alu_data_in  (alu_data_in),
    .lsb_valid_in (lsb_valid_in),
    .lsb_tag_in   (lsb_tag_in),
    .lsb_data_in  (lsb_data_in),
    .ready_c      (dec_q1_ready_out),
    .value_c      (dec_q1_value_out)
  );

  rob_query_port u_query_q2 (
    .tag_in       (dec_q2_tag_in),
    .ready_vec_in (ready_vec_c),
    .value_vec_in (value_vec_c),
    .alu_valid_in (alu_valid_in),
    .alu_tag_in   (alu_tag_in),
    .alu_data_in  (alu_data_in),
    .lsb_valid_in (lsb_valid_in),
    .lsb_tag_in   (lsb_tag_in),
    .lsb_data_in  (lsb_data_in),
    .ready_c      (dec_q2_ready_out),
    .value_c      (dec_q2_value_out)
  );

  // Next state: write-back, allocate, commit; a mispredict overrides all of it.
  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      entries_d[i] = entries_q[i];
    end
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q + CNT_WIDTH'(alloc_c) - CNT_WIDTH'(commit_c);
    commit_signal_d = 1'b0;
    commit_tag_d    = NULL_TAG;
    commit_data_d   = ZERO_WORD;
    commit_target_d = '0;
    store_commit_d  = 1'b0;
    store_tag_d     = NULL_TAG;
    flush_d         = 1'b0;
    flush_pc_d      = ZERO_WORD;

    if (alu_hit_c) begin
      entries_d[alu_idx_c].ready = 1'b1;
      entries_d[alu_idx_c].value = alu_data_in;
      entries_d[alu_idx_c].taken = alu_taken_in;
    end
    if (lsb_hit_c) begin
      entries_d[lsb_idx_c].ready = 1'b1;
      entries_d[lsb_idx_c].value = lsb_data_in;
    end

    if (alloc_c) begin
      entries_d[tail_q].busy       = 1'b1;
      entries_d[tail_q].ready      = 1'b0;
      entries_d[tail_q].rd         = dec_rd_in;
      entries_d[tail_q].has_rd     = dec_has_rd_in;
      entries_d[tail_q].is_branch  = dec_is_branch_in;
      entries_d[tail_q].is_store   = dec_is_store_in;
      entries_d[tail_q].pred_taken = dec_pred_taken_in;
      entries_d[tail_q].taken      = 1'b0;
      entries_d[tail_q].value      = ZERO_WORD;
      tail_d                       = tail_q + IDX_WIDTH'(1);
    end

    if (commit_c) begin
      entries_d[head_q].busy = 1'b0;
      head_d                 = head_q + IDX_WIDTH'(1);
      if (head_entry_c.has_rd && (head_entry_c.rd != '0)) begin
        commit_signal_d = 1'b1;
        commit_tag_d    = idx_to_tag(head_q);
        commit_data_d   = head_entry_c.value;
        commit_target_d = head_entry_c.rd;
      end
      if (head_entry_c.is_store) begin
        store_commit_d = 1'b1;
        store_tag_d    = idx_to_tag(head_q);
      end
    end

    if (mispredict_c) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_d[i]      = entries_q[i];
        entries_d[i].busy = 1'b0;
      end
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      flush_pc_d = head_entry_c.value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_signal_q <= 1'b0;
      commit_tag_q    <= NULL_TAG;
      commit_data_q   <= ZERO_WORD;
      commit_target_q <= '0;
      store_commit_q  <= 1'b0;
      store_tag_q     <= NULL_TAG;
      flush_q         <= 1'b0;
      flush_pc_q      <= ZERO_WORD;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_signal_q <= commit_signal_d;
      commit_tag_q    <= commit_tag_d;
      commit_data_q   <= commit_data_d;
      commit_target_q <= commit_target_d;
      store_commit_q  <= store_commit_d;
      store_tag_q     <= store_tag_d;
      flush_q         <= flush_d;
      flush_pc_q      <= flush_pc_d;
    end
  end

  assign rob_commit_signal_out = commit_signal_q;
  assign rob_commit_tag_out    = commit_tag_q;
  assign rob_commit_data_out   = commit_data_q;
  assign rob_commit_target_out = commit_target_q;
  assign rob_store_commit_out  = store_commit_q;
  assign rob_store_tag_out     = store_tag_q;
  assign rob_flush_out         = flush_q;
  assign rob_flush_pc_out      = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: program-order queue model, directed scenarios, random traffic.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  dis_tag_out;
  logic        rob_full_out;
  logic        dec_issue_in, dec_has_rd_in, dec_is_branch_in, dec_is_store_in, dec_pred_taken_in;
  logic [4:0]  dec_rd_in, dec_q1_tag_in, dec_q2_tag_in;
  logic        dec_q1_ready_out, dec_q2_ready_out;
  logic [31:0] dec_q1_value_out, dec_q2_value_out;
  logic        alu_valid_in, alu_taken_in, lsb_valid_in;
  logic [4:0]  alu_tag_in, lsb_tag_in;
  logic [31:0] alu_data_in, lsb_data_in;
  logic        rob_commit_signal_out, rob_store_commit_out, rob_flush_out;
  logic [4:0]  rob_commit_tag_out, rob_commit_target_out, rob_store_tag_out;
  logic [31:0] rob_commit_data_out, rob_flush_pc_out;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .dis_tag_out(dis_tag_out), .rob_full_out(rob_full_out),
    .dec_issue_in(dec_issue_in), .dec_rd_in(dec_rd_in), .dec_has_rd_in(dec_has_rd_in),
    .dec_is_branch_in(dec_is_branch_in), .dec_is_store_in(dec_is_store_in),
    .dec_pred_taken_in(dec_pred_taken_in), .dec_q1_tag_in(dec_q1_tag_in),
    .dec_q2_tag_in(dec_q2_tag_in), .dec_q1_ready_out(dec_q1_ready_out),
    .dec_q2_ready_out(dec_q2_ready_out), .dec_q1_value_out(dec_q1_value_out),
    .dec_q2_value_out(dec_q2_value_out), .alu_valid_in(alu_valid_in), .alu_tag_in(alu_tag_in),
    .alu_data_in(alu_data_in), .alu_taken_in(alu_taken_in), .lsb_valid_in(lsb_valid_in),
    .lsb_tag_in(lsb_tag_in), .lsb_data_in(lsb_data_in),
    .rob_commit_signal_out(rob_commit_signal_out), .rob_commit_tag_out(rob_commit_tag_out),
    .rob_commit_data_out(rob_commit_data_out), .rob_commit_target_out(rob_commit_target_out),
    .rob_store_commit_out(rob_store_commit_out), .rob_store_tag_out(rob_store_tag_out),
    .rob_flush_out(rob_flush_out), .rob_flush_pc_out(rob_flush_pc_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: tags in program order plus per-tag state.
  int          q[$];
  int          next_tag;
  bit          m_busy[0:16], m_ready[0:16], m_hasrd[0:16], m_br[0:16], m_st[0:16];
  bit          m_pred[0:16], m_taken[0:16];
  logic [4:0]  m_rd[0:16];
  logic [31:0] m_value[0:16];
  logic        exp_csig, exp_ssig, exp_fsig;
  logic [4:0]  exp_ctag, exp_ctgt, exp_stag;
  logic [31:0] exp_cdata, exp_fpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_exp();
    exp_csig = 0; exp_ctag = 0; exp_cdata = 0; exp_ctgt = 0;
    exp_ssig = 0; exp_stag = 0; exp_fsig = 0; exp_fpc = 0;
  endtask

  task automatic model_reset();
    q.delete();
    next_tag = 1;
    for (int t = 0; t <= 16; t++) begin
      m_busy[t] = 0; m_ready[t] = 0; m_hasrd[t] = 0; m_br[t] = 0; m_st[t] = 0;
      m_pred[t] = 0; m_taken[t] = 0; m_rd[t] = 0; m_value[t] = 0;
    end
    clear_exp();
  endtask

  task automatic model_step();
    int h;
    bit full, do_commit;
    clear_exp();
    if (!rst) return;
    full = (q.size() == 16);
    h = 0;
    if (q.size() > 0) h = q[0];
    do_commit = (h != 0) && m_ready[h];
    if (do_commit) begin
      if (m_hasrd[h] && m_rd[h] != 0) begin
        exp_csig = 1; exp_ctag = 5'(h); exp_cdata = m_value[h]; exp_ctgt = m_rd[h];
      end
      if (m_st[h]) begin
        exp_ssig = 1; exp_stag = 5'(h);
      end
      if (m_br[h] && (m_taken[h] != m_pred[h])) begin
        exp_fsig = 1; exp_fpc = m_value[h];
        for (int t = 0; t <= 16; t++) m_busy[t] = 0;
        q.delete();
        next_tag = 1;
        return;
      end
    end
    if (alu_valid_in && alu_tag_in >= 1 && alu_tag_in <= 16 && m_busy[alu_tag_in]) begin
      m_ready[alu_tag_in] = 1; m_value[alu_tag_in] = alu_data_in; m_taken[alu_tag_in] = alu_taken_in;
    end
    if (lsb_valid_in && lsb_tag_in >= 1 && lsb_tag_in <= 16 && m_busy[lsb_tag_in]) begin
      m_ready[lsb_tag_in] = 1; m_value[lsb_tag_in] = lsb_data_in;
    end
    if (dec_issue_in && !full) begin
      m_busy[next_tag] = 1; m_ready[next_tag] = 0; m_rd[next_tag] = dec_rd_in;
      m_hasrd[next_tag] = dec_has_rd_in; m_br[next_tag] = dec_is_branch_in;
      m_st[next_tag] = dec_is_store_in; m_pred[next_tag] = dec_pred_taken_in;
      m_taken[next_tag] = 0;
      q.push_back(next_tag);
      next_tag = (next_tag == 16) ? 1 : next_tag + 1;
    end
    if (do_commit) begin
      void'(q.pop_front());
      m_busy[h] = 0;
    end
  endtask

  function automatic void model_query(input logic [4:0] tag, output logic rdy, output logic [31:0] val);
    rdy = 0; val = 0;
    if (tag == 0 || tag > 16) return;
    if (alu_valid_in && alu_tag_in == tag) begin
      rdy = 1; val = alu_data_in;
    end else if (lsb_valid_in && lsb_tag_in == tag) begin
      rdy = 1; val = lsb_data_in;
    end else if (m_ready[tag]) begin
      rdy = 1; val = m_value[tag];
    end
  endfunction

  always @(posedge clk) model_step();

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic r1, r2;
    logic [31:0] v1, v2;
    #2;
    if (cmp_en) begin
      model_query(dec_q1_tag_in, r1, v1);
      model_query(dec_q2_tag_in, r2, v2);
      check("dis_tag", 32'(dis_tag_out), 32'(next_tag));
      check("full", 32'(rob_full_out), 32'(q.size() == 16));
      check("q1_ready", 32'(dec_q1_ready_out), 32'(r1));
      check("q1_value", dec_q1_value_out, v1);
      check("q2_ready", 32'(dec_q2_ready_out), 32'(r2));
      check("q2_value", dec_q2_value_out, v2);
      check("commit_signal", 32'(rob_commit_signal_out), 32'(exp_csig));
      check("commit_tag", 32'(rob_commit_tag_out), 32'(exp_ctag));
      check("commit_data", rob_commit_data_out, exp_cdata);
      check("commit_target", 32'(rob_commit_target_out), 32'(exp_ctgt));
      check("store_commit", 32'(rob_store_commit_out), 32'(exp_ssig));
      check("store_tag", 32'(rob_store_tag_out), 32'(exp_stag));
      check("flush", 32'(rob_flush_out), 32'(exp_fsig));
      check("flush_pc", rob_flush_pc_out, exp_fpc);
    end
  end

  task automatic set_idle();
    dec_issue_in = 0; dec_rd_in = 0; dec_has_rd_in = 0; dec_is_branch_in = 0;
    dec_is_store_in = 0; dec_pred_taken_in = 0; dec_q1_tag_in = 0; dec_q2_tag_in = 0;
    alu_valid_in = 0; alu_tag_in = 0; alu_data_in = 0; alu_taken_in = 0;
    lsb_valid_in = 0; lsb_tag_in = 0; lsb_data_in = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
    set_idle();
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic has_rd, input logic br,
                           input logic st, input logic pred);
    dec_issue_in = 1; dec_rd_in = rd; dec_has_rd_in = has_rd;
    dec_is_branch_in = br; dec_is_store_in = st; dec_pred_taken_in = pred;
  endtask

  task automatic set_alu(input logic [4:0] tag, input logic [31:0] data, input logic taken);
    alu_valid_in = 1; alu_tag_in = tag; alu_data_in = data; alu_taken_in = taken;
  endtask

  task automatic set_lsb(input logic [4:0] tag, input logic [31:0] data);
    lsb_valid_in = 1; lsb_tag_in = tag; lsb_data_in = data;
  endtask

  task automatic do_reset();
    rst = 0;
    model_reset();
    tick();
    rst = 1;
  endtask

  task automatic rand_cycle();
    int pend[$];
    int a_t, l_t;
    for (int t = 1; t <= 16; t++) if (m_busy[t] && !m_ready[t]) pend.push_back(t);
    if ($urandom_range(99) < 55) begin
      int kind;
      kind = $urandom_range(99);
      set_issue(5'($urandom_range(31)), 1'($urandom_range(1)), kind < 12,
                kind >= 12 && kind < 27, 1'($urandom_range(1)));
    end
    a_t = 0;
    if (pend.size() > 0 && $urandom_range(99) < 45) begin
      a_t = pend[$urandom_range(pend.size() - 1)];
      set_alu(5'(a_t), $urandom, 1'($urandom_range(1)));
    end
    if (pend.size() > 0 && $urandom_range(99) < 35) begin
      l_t = pend[$urandom_range(pend.size() - 1)];
      if (l_t != a_t && !m_br[l_t]) set_lsb(5'(l_t), $urandom);
    end else if ($urandom_range(99) < 6) begin
      l_t = $urandom_range(16);
      if (!m_busy[l_t]) set_lsb(5'(l_t), $urandom);
    end
    dec_q1_tag_in = 5'($urandom_range(16));
    dec_q2_tag_in = 5'($urandom_range(16));
  endtask

  initial begin
    set_idle();
    rst = 0;
    model_reset();
    @(negedge clk);
    cmp_en = 1;
    #3;
    check("reset_dis_tag", 32'(dis_tag_out), 32'd1);
    check("reset_full", 32'(rob_full_out), 32'd0);
    check("reset_commit", 32'(rob_commit_signal_out), 32'd0);
    rst = 1;

    // In-order commit of out-of-order results.
    set_issue(5'd1, 1, 0, 0, 0); tick();
    set_issue(5'd2, 1, 0, 0, 0); tick();
    set_issue(5'd3, 1, 0, 0, 0); tick();
    set_alu(5'd3, 32'd30, 0); tick();
    set_alu(5'd1, 32'd10, 0); tick();
    set_lsb(5'd2, 32'd20); tick();
    check("c1_sig", 32'(rob_commit_signal_out), 32'd1);
    check("c1_tag", 32'(rob_commit_tag_out), 32'd1);
    check("c1_data", rob_commit_data_out, 32'd10);
    check("c1_target", 32'(rob_commit_target_out), 32'd1);
    tick();
    check("c2_tag", 32'(rob_commit_tag_out), 32'd2);
    check("c2_data", rob_commit_data_out, 32'd20);
    tick();
    check("c3_tag", 32'(rob_commit_tag_out), 32'd3);
    check("c3_data", rob_commit_data_out, 32'd30);
    tick();
    check("c4_idle", 32'(rob_commit_signal_out), 32'd0);

    // Fill, overfill, and wrap.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_issue(5'(7 + i), 1, 0, 0, 0); tick();
    end
    check("fill_full", 32'(rob_full_out), 32'd1);
    check("fill_dis_tag", 32'(dis_tag_out), 32'd1);
    set_issue(5'd9, 1, 0, 0, 0); tick();
    check("over_full", 32'(rob_full_out), 32'd1);
    check("over_dis_tag", 32'(dis_tag_out), 32'd1);
    set_lsb(5'd1, 32'h77); tick();
    set_issue(5'd9, 1, 0, 0, 0); tick();
    check("wrap_commit_tag", 32'(rob_commit_tag_out), 32'd1);
    check("wrap_commit_data", rob_commit_data_out, 32'h77);
    check("wrap_not_full", 32'(rob_full_out), 32'd0);
    set_issue(5'd9, 1, 0, 0, 0); tick();
    check("wrap_full_again", 32'(rob_full_out), 32'd1);
    check("wrap_dis_tag", 32'(dis_tag_out), 32'd2);

    // Mispredicted branch flushes younger work.
    do_reset();
    set_issue(5'd0, 0, 1, 0, 0); tick();
    set_issue(5'd4, 1, 0, 0, 0); tick();
    set_issue(5'd5, 1, 0, 0, 0); tick();
    set_alu(5'd1, 32'h1000, 1); tick();
    set_issue(5'd6, 1, 0, 0, 0); set_lsb(5'd2, 32'h99); tick();
    check("flush_sig", 32'(rob_flush_out), 32'd1);
    check("flush_pc", rob_flush_pc_out, 32'h1000);
    check("flush_dis_tag", 32'(dis_tag_out), 32'd1);
    check("flush_commit", 32'(rob_commit_signal_out), 32'd0);
    dec_q1_tag_in = 5'd2;
    #1 check("flush_q_stale", 32'(dec_q1_ready_out), 32'd0);
    set_lsb(5'd3, 32'h55); tick();
    tick();
    check("flush_after", 32'(rob_flush_out), 32'd0);
    check("flush_no_commit", 32'(rob_commit_signal_out), 32'd0);

    // Query bypass and NULL tag.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_issue(5'(10 + i), 1, 0, 0, 0); tick();
    end
    dec_q1_tag_in = 5'd4; dec_q2_tag_in = 5'd0;
    set_alu(5'd4, 32'hAB, 0);
    #1;
    check("bypass_ready", 32'(dec_q1_ready_out), 32'd1);
    check("bypass_value", dec_q1_value_out, 32'hAB);
    check("null_ready", 32'(dec_q2_ready_out), 32'd0);
    check("null_value", dec_q2_value_out, 32'd0);
    tick();

    // Store release and rd=0 retire.
    do_reset();
    set_issue(5'd0, 0, 0, 1, 0); tick();
    set_issue(5'd0, 1, 0, 0, 0); tick();
    set_lsb(5'd1, 32'h55); tick();
    set_alu(5'd2, 32'h66, 0); tick();
    check("store_sig", 32'(rob_store_commit_out), 32'd1);
    check("store_tag", 32'(rob_store_tag_out), 32'd1);
    check("store_no_commit", 32'(rob_commit_signal_out), 32'd0);
    tick();
    check("rd0_no_commit", 32'(rob_commit_signal_out), 32'd0);
    check("rd0_no_store", 32'(rob_store_commit_out), 32'd0);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_issue(5'(1 + i), 1, 0, 0, 0); tick();
    end
    set_alu(5'd1, 32'hCAFE, 0); tick();
    tick();
    check("pre_rst_commit", 32'(rob_commit_signal_out), 32'd1);
    rst = 0;
    model_reset();
    #1;
    check("rst_commit", 32'(rob_commit_signal_out), 32'd0);
    check("rst_data", rob_commit_data_out, 32'd0);
    check("rst_tag", 32'(rob_commit_tag_out), 32'd0);
    check("rst_dis_tag", 32'(dis_tag_out), 32'd1);
    check("rst_full", 32'(rob_full_out), 32'd0);
    tick();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      set_alu(5'(2 + i), 32'h1234, 0); tick();
      check("post_rst_quiet", 32'(rob_commit_signal_out), 32'd0);
    end

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_cycle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
